// File: rtl/seq_subtractor_if.sv
// Start/done handshake and operand/result bus of the multi-cycle subtractor.
// The master drives the request; the slave (the subtractor) returns status and result.
interface seq_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, resolved DIGIT bits per clock from the
// LSB upward through a registered borrow, with a start/busy/done handshake.
module seq_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst,
  seq_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT:0]   dig_full;
  logic             accept;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // A request is taken in IDLE and also in DONE, which gives back-to-back operation.
  assign accept = bus.start && (state != RUN);

  // One digit of the borrow chain; the top bit of dig_full is the borrow into the next digit.
  always_comb begin
    dig_a    = op_a[idx*DIGIT +: DIGIT];
    dig_b    = op_b[idx*DIGIT +: DIGIT];
    dig_full = {1'b0, dig_a} - {1'b0, dig_b} - {{DIGIT{1'b0}}, borrow};
    res_next = res;
    res_next[idx*DIGIT +: DIGIT] = dig_full[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= bus.a;
        op_b   <= bus.b;
        borrow <= bus.bin;
        idx    <= '0;
      end
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          res    <= res_next;
          borrow <= dig_full[DIGIT];
          idx    <= idx + 1'b1;
          // Architectural results change only here and hold until the next completion.
          if (idx == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            diff_q <= res_next;
            bout_q <= dig_full[DIGIT];
            ovf_q  <= (op_a[WIDTH-1] ^ op_b[WIDTH-1]) &
                      (res_next[WIDTH-1] ^ op_a[WIDTH-1]);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed handshake/reset cases on a 16/4 instance,
// a width-8 digit sweep, and random operands against a plain-arithmetic reference.
module tb_seq_subtractor;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_subtractor_if #(.WIDTH(16)) bus16 ();
  seq_subtractor_if #(.WIDTH(8))  bus8a ();
  seq_subtractor_if #(.WIDTH(8))  bus8b ();
  seq_subtractor_if #(.WIDTH(8))  bus8c ();

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) dut16  (.clk(clk), .rst(rst), .bus(bus16));
  seq_subtractor #(.WIDTH(8),  .DIGIT(1)) dut8d1 (.clk(clk), .rst(rst), .bus(bus8a));
  seq_subtractor #(.WIDTH(8),  .DIGIT(2)) dut8d2 (.clk(clk), .rst(rst), .bus(bus8b));
  seq_subtractor #(.WIDTH(8),  .DIGIT(8)) dut8d8 (.clk(clk), .rst(rst), .bus(bus8c));

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer subtraction, unsigned compare and signed range test.
  function automatic void refSub(input int w, input longint ua, input longint ub, input bit bi,
                                 output longint d, output bit bo, output bit ov);
    longint modv, half, full, sa, sb, s;
    modv = longint'(1) << w;
    half = modv >> 1;
    full = ua - ub - longint'(bi);
    d    = (full < 0) ? full + modv : full;
    bo   = (ua < ub + longint'(bi));
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    s    = sa - sb - longint'(bi);
    ov   = (s < -half) || (s > half - 1);
  endfunction

  // Called at the negedge right after the accepting edge; returns edges until done.
  task automatic waitDone16(input int glitchAt, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (bus16.done !== 1'b1 && lat < 20) begin
      if (bus16.busy === 1'b1) busyCnt++;
      if (glitchAt >= 0 && lat == glitchAt) begin
        bus16.start = 1'b1;
        bus16.a     = 16'hFFFF;
        bus16.b     = 16'h0001;
        bus16.bin   = 1'b1;
      end else if (glitchAt >= 0 && lat == glitchAt + 1) begin
        bus16.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (bus16.done !== 1'b1) checkOutput("done16_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkResult16(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input bit bi);
    longint d;
    bit bo, ov;
    refSub(16, longint'(a), longint'(b), bi, d, bo, ov);
    checkOutput({tag, "_diff"}, 64'(bus16.diff), 64'(d));
    checkOutput({tag, "_bout"}, 64'(bus16.bout), 64'(bo));
    checkOutput({tag, "_ovf"},  64'(bus16.ovf),  64'(ov));
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit bi,
                               input int glitchAt, input string tag);
    int lat, bc;
    @(negedge clk);
    bus16.a     = a;
    bus16.b     = b;
    bus16.bin   = bi;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    bus16.bin   = 1'($urandom);
    waitDone16(glitchAt, lat, bc);
    checkOutput({tag, "_lat"}, 64'(lat), 64'd4);
    checkOutput({tag, "_busycycles"}, 64'(bc), 64'd4);
    checkOutput({tag, "_busy_at_done"}, 64'(bus16.busy), 64'd0);
    checkResult16(tag, a, b, bi);
  endtask

  task automatic sweep8(input logic [7:0] a, input logic [7:0] b, input bit bi, input string tag);
    int lat, latA, latB, latC;
    logic [9:0] rA, rB, rC;
    longint d;
    bit bo, ov;
    latA = -1; latB = -1; latC = -1;
    rA = '0; rB = '0; rC = '0;
    @(negedge clk);
    bus8a.a = a; bus8a.b = b; bus8a.bin = bi; bus8a.start = 1'b1;
    bus8b.a = a; bus8b.b = b; bus8b.bin = bi; bus8b.start = 1'b1;
    bus8c.a = a; bus8c.b = b; bus8c.bin = bi; bus8c.start = 1'b1;
    @(negedge clk);
    bus8a.start = 1'b0; bus8b.start = 1'b0; bus8c.start = 1'b0;
    bus8a.a = 8'($urandom); bus8b.b = 8'($urandom); bus8c.bin = ~bi;
    lat = 0;
    while (lat < 12 && (latA < 0 || latB < 0 || latC < 0)) begin
      if (bus8a.done === 1'b1 && latA < 0) begin latA = lat; rA = {bus8a.ovf, bus8a.bout, bus8a.diff}; end
      if (bus8b.done === 1'b1 && latB < 0) begin latB = lat; rB = {bus8b.ovf, bus8b.bout, bus8b.diff}; end
      if (bus8c.done === 1'b1 && latC < 0) begin latC = lat; rC = {bus8c.ovf, bus8c.bout, bus8c.diff}; end
      @(negedge clk);
      lat++;
    end
    refSub(8, longint'(a), longint'(b), bi, d, bo, ov);
    checkOutput({tag, "_d1_lat"}, 64'(latA), 64'd8);
    checkOutput({tag, "_d2_lat"}, 64'(latB), 64'd4);
    checkOutput({tag, "_d8_lat"}, 64'(latC), 64'd1);
    checkOutput({tag, "_d1_res"}, 64'(rA), 64'({ov, bo, d[7:0]}));
    checkOutput({tag, "_d2_res"}, 64'(rB), 64'({ov, bo, d[7:0]}));
    checkOutput({tag, "_d8_res"}, 64'(rC), 64'({ov, bo, d[7:0]}));
  endtask

  initial begin
    int lat, bc, doneSeen;
    rst = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
    bus8a.start = 1'b0; bus8a.a = '0; bus8a.b = '0; bus8a.bin = 1'b0;
    bus8b.start = 1'b0; bus8b.a = '0; bus8b.b = '0; bus8b.bin = 1'b0;
    bus8c.start = 1'b0; bus8c.a = '0; bus8c.b = '0; bus8c.bin = 1'b0;
    #22 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 64'(bus16.busy), 64'd0);
    checkOutput("rst_done", 64'(bus16.done), 64'd0);
    checkOutput("rst_diff", 64'(bus16.diff), 64'd0);
    checkOutput("rst_bout", 64'(bus16.bout), 64'd0);
    checkOutput("rst_ovf",  64'(bus16.ovf),  64'd0);

    applyStimulus(16'h1234, 16'h0234, 1'b0, -1, "basic");
    applyStimulus(16'h0000, 16'h0001, 1'b0, -1, "wrap");
    applyStimulus(16'h8000, 16'h0001, 1'b0, -1, "ovf");
    applyStimulus(16'h0005, 16'h0005, 1'b1, -1, "bin_ripple");
    applyStimulus(16'h1000, 16'h0000, 1'b1, -1, "bin_borrow");

    $display("[TB] start pulse during RUN");
    applyStimulus(16'h4321, 16'h1111, 1'b0, 2, "glitch");
    @(negedge clk);
    checkOutput("glitch_not_queued", 64'({bus16.busy, bus16.done}), 64'd0);

    $display("[TB] start held across DONE");
    @(negedge clk);
    bus16.a = 16'h8000; bus16.b = 16'h0001; bus16.bin = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    waitDone16(-1, lat, bc);
    checkOutput("b2b_first_lat", 64'(lat), 64'd4);
    checkResult16("b2b_first", 16'h8000, 16'h0001, 1'b0);
    bus16.a = 16'h0005; bus16.b = 16'h0005; bus16.bin = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    checkOutput("b2b_reaccept", 64'({bus16.busy, bus16.done}), 64'b10);
    waitDone16(-1, lat, bc);
    checkOutput("b2b_second_lat", 64'(lat), 64'd4);
    checkResult16("b2b_second", 16'h0005, 16'h0005, 1'b1);

    $display("[TB] reset during RUN");
    @(negedge clk);
    bus16.a = 16'h00FF; bus16.b = 16'h0001; bus16.bin = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus16.busy), 64'd0);
    checkOutput("abort_done", 64'(bus16.done), 64'd0);
    checkOutput("abort_diff", 64'(bus16.diff), 64'd0);
    checkOutput("abort_bout", 64'(bus16.bout), 64'd0);
    checkOutput("abort_ovf",  64'(bus16.ovf),  64'd0);
    #1 rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.done === 1'b1 || bus16.busy === 1'b1) doneSeen = 1;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    applyStimulus(16'hABCD, 16'h1234, 1'b1, -1, "post_rst");

    $display("[TB] width-8 digit sweep");
    sweep8(8'h00, 8'h01, 1'b0, "s8_wrap");
    sweep8(8'h80, 8'h01, 1'b0, "s8_ovf");
    sweep8(8'h05, 8'h05, 1'b1, "s8_bin");
    for (int i = 0; i < 150; i++)
      sweep8(8'($urandom), 8'($urandom), 1'($urandom), "s8_rand");

    $display("[TB] random 16-bit operands");
    for (int i = 0; i < 1000; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), -1, "rand16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
